// File: rtl/onchip_ram_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM. It grants one access per clock,
// either round-robin or with m0 at fixed priority, and returns read data one cycle later.
module onchip_ram_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RD_RET = 1'b1;

    logic       req0, req1;
    logic       grant0, grant1;
    logic       any_grant, win_write, win_read;
    logic       last_grant;
    logic [0:0] rd_state, rd_state_nxt;
    logic       rd_id_p1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // last_grant=1 means m1 went last, so m0 takes the next contended cycle
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if (ROUND_ROBIN != 0) begin
                    grant0 = last_grant;
                    grant1 = ~last_grant;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign any_grant = grant0 | grant1;
    assign win_write = grant1 ? m1_write : m0_write;
    assign win_read  = any_grant & ~win_write;

    assign m0_waitrequest = reset | (req0 & ~grant0);
    assign m1_waitrequest = reset | (req1 & ~grant1);

    assign ram_chipselect = any_grant;
    assign ram_write      = any_grant & win_write;
    assign ram_address    = grant1 ? m1_address : m0_address;
    assign ram_writedata  = grant1 ? m1_writedata : m0_writedata;
    assign ram_byteenable = win_write ? (grant1 ? m1_byteenable : m0_byteenable)
                                      : {BE_W{1'b1}};
    assign ram_clken      = 1'b1;

    always_comb begin
        rd_state_nxt = IDLE;
        case (rd_state)
            IDLE:    rd_state_nxt = win_read ? RD_RET : IDLE;
            RD_RET:  rd_state_nxt = win_read ? RD_RET : IDLE;
            default: rd_state_nxt = IDLE;
        endcase
    end

    // stage p0 -> p1: RAM address edge, read return tagged with the issuing master
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_state   <= IDLE;
            rd_id_p1   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            if (any_grant)
                last_grant <= grant1;
            if (win_read)
                rd_id_p1 <= grant1;
        end
    end

    // A read in flight when reset rises must not report back
    assign m0_readdatavalid = ~reset & (rd_state == RD_RET) & ~rd_id_p1;
    assign m1_readdatavalid = ~reset & (rd_state == RD_RET) &  rd_id_p1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Bench for onchip_ram_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream and are compared every cycle against an abstract arbitration/memory model.
module tb_onchip_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ram_clr;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;

    logic        a_wait0, a_wait1, a_v0, a_v1, a_cs, a_we, a_clken;
    logic [31:0] a_rd0, a_rd1, a_wd, a_q;
    logic [9:0]  a_addr;
    logic [3:0]  a_be;
    logic        b_wait0, b_wait1, b_v0, b_v1, b_cs, b_we, b_clken;
    logic [31:0] b_rd0, b_rd1, b_wd, b_q;
    logic [9:0]  b_addr;
    logic [3:0]  b_be;

    onchip_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_wait0),
        .m0_readdata(a_rd0), .m0_readdatavalid(a_v0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_wait1),
        .m1_readdata(a_rd1), .m1_readdatavalid(a_v1),
        .ram_address(a_addr), .ram_byteenable(a_be), .ram_chipselect(a_cs),
        .ram_write(a_we), .ram_writedata(a_wd), .ram_clken(a_clken), .ram_readdata(a_q)
    );

    onchip_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_wait0),
        .m0_readdata(b_rd0), .m0_readdatavalid(b_v0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_wait1),
        .m1_readdata(b_rd1), .m1_readdatavalid(b_v1),
        .ram_address(b_addr), .ram_byteenable(b_be), .ram_chipselect(b_cs),
        .ram_write(b_we), .ram_writedata(b_wd), .ram_clken(b_clken), .ram_readdata(b_q)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural RAMs behind each arbiter: registered q, byte-enabled writes
    logic [31:0] a_mem [0:1023];
    logic [31:0] b_mem [0:1023];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int k = 0; k < 1024; k++) a_mem[k] <= '0;
        end else if (a_cs) begin
            if (a_we) a_mem[a_addr] <= merge(a_mem[a_addr], a_wd, a_be);
            else      a_q <= a_mem[a_addr];
        end
    end
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int k = 0; k < 1024; k++) b_mem[k] <= '0;
        end else if (b_cs) begin
            if (b_we) b_mem[b_addr] <= merge(b_mem[b_addr], b_wd, b_be);
            else      b_q <= b_mem[b_addr];
        end
    end

    // Reference model state, index 0 = round-robin, 1 = fixed priority
    logic [31:0] exp_mem [2][1024];
    int          m_last [2];
    int          m_pend [2];
    int          m_pid  [2];
    logic [31:0] m_pdata[2];
    int          ew     [2];
    int          tests = 0;
    int          fails = 0;
    int          xp_port = -1;
    logic [31:0] xp_data;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int winner(int i);
        logic r0, r1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (reset) return -1;
        if (r0 && r1) return (i == 0) ? ((m_last[i] == 0) ? 1 : 0) : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic logic is_wr(int w);
        return (w == 1) ? m1_write : m0_write;
    endfunction

    task automatic check_inst(int i, string p, logic w0, logic w1, logic v0, logic v1,
                              logic [31:0] rd0, logic [31:0] rd1, logic cs, logic we,
                              logic [9:0] addr, logic [3:0] be, logic [31:0] wd, logic ck);
        int  w;
        logic r0, r1, wr;
        w  = winner(i);
        ew[i] = w;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        wr = (w >= 0) && is_wr(w);
        check({p, ".wait0"}, 32'(w0), 32'(reset || (r0 && w != 0)));
        check({p, ".wait1"}, 32'(w1), 32'(reset || (r1 && w != 1)));
        check({p, ".cs"},    32'(cs), 32'(w >= 0));
        check({p, ".we"},    32'(we), 32'(wr));
        check({p, ".clken"}, 32'(ck), 32'd1);
        if (w >= 0) begin
            check({p, ".addr"}, 32'(addr), 32'((w == 1) ? m1_address : m0_address));
            check({p, ".be"},   32'(be),   32'(wr ? ((w == 1) ? m1_byteenable : m0_byteenable) : 4'hF));
            if (wr) check({p, ".wdata"}, wd, (w == 1) ? m1_writedata : m0_writedata);
        end
        check({p, ".rdv0"}, 32'(v0), 32'(!reset && m_pend[i] != 0 && m_pid[i] == 0));
        check({p, ".rdv1"}, 32'(v1), 32'(!reset && m_pend[i] != 0 && m_pid[i] == 1));
        if (!reset && m_pend[i] != 0)
            check({p, ".rdata"}, (m_pid[i] == 1) ? rd1 : rd0, m_pdata[i]);
    endtask

    task automatic update_model(int i);
        int w;
        logic [9:0] a;
        w = ew[i];
        if (reset) begin
            m_last[i] = 1;
            m_pend[i] = 0;
        end else begin
            m_pend[i] = 0;
            if (w >= 0) begin
                m_last[i] = w;
                a = (w == 1) ? m1_address : m0_address;
                if (is_wr(w))
                    exp_mem[i][a] = merge(exp_mem[i][a], (w == 1) ? m1_writedata : m0_writedata,
                                          (w == 1) ? m1_byteenable : m0_byteenable);
                else begin
                    m_pend[i]  = 1;
                    m_pid[i]   = w;
                    m_pdata[i] = exp_mem[i][a];
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_inst(0, "rr", a_wait0, a_wait1, a_v0, a_v1, a_rd0, a_rd1, a_cs, a_we, a_addr, a_be, a_wd, a_clken);
        check_inst(1, "fp", b_wait0, b_wait1, b_v0, b_v1, b_rd0, b_rd1, b_cs, b_we, b_addr, b_be, b_wd, b_clken);
        if (xp_port >= 0) begin
            check("known.rdv", 32'((xp_port == 1) ? a_v1 : a_v0), 32'd1);
            check("known.rdata", (xp_port == 1) ? a_rd1 : a_rd0, xp_data);
            xp_port = -1;
        end
        @(posedge clk);
        update_model(0);
        update_model(1);
        #1;
    endtask

    task automatic set0(logic rd, logic wr, logic [9:0] a, logic [3:0] be, logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask
    task automatic set1(logic rd, logic wr, logic [9:0] a, logic [3:0] be, logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 1024; k++) exp_mem[i][k] = '0;
            m_last[i] = 1; m_pend[i] = 0; m_pid[i] = 0; m_pdata[i] = '0; ew[i] = -1;
        end
        xp_data = '0;
        ram_clr = 1'b1;
        reset   = 1'b1;
        set0(0, 0, 10'h0, 4'h0, 32'h0);
        set1(0, 0, 10'h0, 4'h0, 32'h0);
        step();
        ram_clr = 1'b0;
        step();
        reset = 1'b0;

        set0(0, 1, 10'h010, 4'hF, 32'hDEADBEEF); step();
        set0(1, 0, 10'h010, 4'h0, 32'h0);        step();
        set0(0, 0, 10'h0, 4'h0, 32'h0);
        xp_port = 0; xp_data = 32'hDEADBEEF;     step();

        set1(0, 1, 10'h3FF, 4'b0101, 32'h12345678); step();
        set1(1, 0, 10'h3FF, 4'h0, 32'h0);           step();
        set1(0, 0, 10'h0, 4'h0, 32'h0);
        xp_port = 1; xp_data = 32'h00340078;        step();

        reset = 1'b1; step(); reset = 1'b0;
        set0(1, 0, 10'h010, 4'h0, 32'h0);
        set1(1, 0, 10'h3FF, 4'h0, 32'h0);
        repeat (6) step();
        set0(0, 0, 10'h0, 4'h0, 32'h0); step();
        set1(0, 0, 10'h0, 4'h0, 32'h0); step();

        set0(1, 0, 10'h020, 4'h0, 32'h0); step();
        reset = 1'b1;
        set1(1, 0, 10'h3FF, 4'h0, 32'h0);
        step(); step();
        reset = 1'b0;
        step(); step();
        set0(0, 0, 10'h0, 4'h0, 32'h0);
        set1(0, 0, 10'h0, 4'h0, 32'h0); step();

        set1(1, 1, 10'h005, 4'hF, 32'hA5A5A5A5); step();
        set1(0, 0, 10'h0, 4'h0, 32'h0);          step();
        set1(1, 0, 10'h005, 4'h0, 32'h0);        step();
        set1(0, 0, 10'h0, 4'h0, 32'h0);
        xp_port = 1; xp_data = 32'hA5A5A5A5;     step();

        for (int n = 0; n < 3000; n++) begin
            int s0, s1;
            reset = ($urandom_range(0, 63) == 0);
            s0 = $urandom_range(0, 3);
            s1 = $urandom_range(0, 3);
            set0(s0[0], s0[1], ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                 4'($urandom), $urandom);
            set1(s1[0], s1[1], ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                 4'($urandom), $urandom);
            step();
        end

        reset = 1'b0;
        set0(0, 0, 10'h0, 4'h0, 32'h0);
        set1(0, 0, 10'h0, 4'h0, 32'h0);
        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
